// File: rtl/tmds_encoder_multi.sv
// Multi-lane TMDS encoder: control, 8b/10b video, video guard band, and
// optional TERC4 data island / island guard band. Each lane has a two-stage
// pipeline and its own running disparity counter.
// Optional feature macro: TMDS_DATA_ISLAND_EN. When it is defined, modes 3/4
// use the TERC4 table. When it is undefined, modes 3/4 decode as CTRL.

// ---------------------------------------------------------------------------
// One TMDS lane: stage 1 transition minimisation, stage 2 DC balance / mode mux
// ---------------------------------------------------------------------------
module tmds_lane #(
    parameter int LANE  = 0,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,      // input symbol valid (stage-1 enable)
    input  logic             s1_valid,  // stage-1 contents valid (stage-2 enable)
    input  logic [2:0]       mode,
    input  logic [7:0]       data,
    input  logic [1:0]       ctrl,
    input  logic [3:0]       terc4,
    output logic [9:0]       q,
    output logic [CNT_W-1:0] disp
);
    localparam logic [2:0] MODE_VIDEO    = 3'd1;
    localparam logic [2:0] MODE_VIDEO_GB = 3'd2;
`ifdef TMDS_DATA_ISLAND_EN
    localparam logic [2:0] MODE_ISLAND    = 3'd3;
    localparam logic [2:0] MODE_ISLAND_GB = 3'd4;
`endif

    localparam logic [9:0] CTRL_00 = 10'b0010101011;
    localparam logic [9:0] CTRL_01 = 10'b1101010100;
    localparam logic [9:0] CTRL_10 = 10'b0010101010;
    localparam logic [9:0] CTRL_11 = 10'b1101010101;
    localparam logic [9:0] GB_A    = 10'b1011001100;
    localparam logic [9:0] GB_B    = 10'b0100110011;

    localparam logic signed [CNT_W-1:0] TWO   = CNT_W'(2);
    localparam logic signed [CNT_W-1:0] EIGHT = CNT_W'(8);

    function automatic logic [3:0] popcnt8(input logic [7:0] d);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) n = n + {3'b000, d[i]};
        return n;
    endfunction

    // XNOR chain when the byte is ones-heavy (ties broken by bit 0), else XOR.
    function automatic logic [8:0] trans_min(input logic [7:0] d);
        logic [8:0] m;
        logic [3:0] n;
        logic       use_xnor;
        n        = popcnt8(d);
        use_xnor = (n > 4'd4) || (n == 4'd4 && !d[0]);
        m[0]     = d[0];
        for (int i = 1; i < 8; i++)
            m[i] = use_xnor ? ~(m[i-1] ^ d[i]) : (m[i-1] ^ d[i]);
        m[8] = ~use_xnor;
        return m;
    endfunction

    function automatic logic [9:0] ctrl_code(input logic [1:0] c);
        logic [9:0] s;
        case (c)
            2'b00:   s = CTRL_00;
            2'b01:   s = CTRL_01;
            2'b10:   s = CTRL_10;
            default: s = CTRL_11;
        endcase
        return s;
    endfunction

`ifdef TMDS_DATA_ISLAND_EN
    function automatic logic [9:0] terc4_code(input logic [3:0] t);
        logic [9:0] s;
        case (t)
            4'h0:    s = 10'b1010011100;
            4'h1:    s = 10'b1001100011;
            4'h2:    s = 10'b1011100100;
            4'h3:    s = 10'b1011100010;
            4'h4:    s = 10'b0101110001;
            4'h5:    s = 10'b0100011110;
            4'h6:    s = 10'b0110001110;
            4'h7:    s = 10'b0100111100;
            4'h8:    s = 10'b1011001100;
            4'h9:    s = 10'b0100111001;
            4'hA:    s = 10'b0110011100;
            4'hB:    s = 10'b1011000110;
            4'hC:    s = 10'b1010001110;
            4'hD:    s = 10'b1001110001;
            4'hE:    s = 10'b0101100011;
            default: s = 10'b1011000011;
        endcase
        return s;
    endfunction
`endif

    // stage-1 state
    logic [8:0] qm_r;
    logic [2:0] mode_r;
    logic [1:0] ctrl_r;
`ifdef TMDS_DATA_ISLAND_EN
    logic [3:0] terc4_r;
`else
    logic       terc4_unused;
    assign terc4_unused = ^terc4;
`endif

    // stage-2 state
    logic [9:0]              q_r;
    logic signed [CNT_W-1:0] cnt;

    // next-state for stage 2
    logic [9:0]              nxt_q;
    logic signed [CNT_W-1:0] nxt_cnt;
    logic [3:0]              n1;
    logic signed [CNT_W-1:0] n1_s;
    logic signed [CNT_W-1:0] diff;   // N1 - N0 of q_m[7:0]
    logic                    qm8;

    // Stage 1: register minimised byte and side-band fields; hold on bubbles
    always_ff @(posedge clk) begin
        if (rst) begin
            qm_r   <= '0;
            mode_r <= '0;
            ctrl_r <= '0;
`ifdef TMDS_DATA_ISLAND_EN
            terc4_r <= '0;
`endif
        end else if (load) begin
            qm_r   <= trans_min(data);
            mode_r <= mode;
            ctrl_r <= ctrl;
`ifdef TMDS_DATA_ISLAND_EN
            terc4_r <= terc4;
`endif
        end
    end

    // Stage 2 combinational: DC balance for video, table lookup otherwise
    always_comb begin
        nxt_q   = ctrl_code(ctrl_r);
        nxt_cnt = '0;
        qm8     = qm_r[8];
        n1      = popcnt8(qm_r[7:0]);
        n1_s    = signed'({{(CNT_W-4){1'b0}}, n1});
        diff    = n1_s - (EIGHT - n1_s);
        case (mode_r)
            MODE_VIDEO: begin
                if (cnt == '0 || n1 == 4'd4) begin
                    nxt_q   = {~qm8, qm8, qm8 ? qm_r[7:0] : ~qm_r[7:0]};
                    nxt_cnt = qm8 ? cnt + diff : cnt - diff;
                end else if ((!cnt[CNT_W-1] && n1 > 4'd4) ||
                             ( cnt[CNT_W-1] && n1 < 4'd4)) begin
                    nxt_q   = {1'b1, qm8, ~qm_r[7:0]};
                    nxt_cnt = cnt + (qm8 ? TWO : '0) - diff;
                end else begin
                    nxt_q   = {1'b0, qm8, qm_r[7:0]};
                    nxt_cnt = cnt + diff - (qm8 ? '0 : TWO);
                end
            end
            MODE_VIDEO_GB: nxt_q = (LANE == 1) ? GB_B : GB_A;
`ifdef TMDS_DATA_ISLAND_EN
            MODE_ISLAND:    nxt_q = terc4_code(terc4_r);
            MODE_ISLAND_GB: nxt_q = (LANE == 0) ? terc4_code(terc4_r) : GB_B;
`endif
            default: nxt_q = ctrl_code(ctrl_r);
        endcase
    end

    // Stage 2: commit symbol and disparity only for valid stage-1 contents
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r <= CTRL_00;
            cnt <= '0;
        end else if (s1_valid) begin
            q_r <= nxt_q;
            cnt <= nxt_cnt;
        end
    end

    assign q    = q_r;
    assign disp = cnt;
endmodule

// ---------------------------------------------------------------------------
// Top: valid shift register plus one lane instance per TMDS channel
// ---------------------------------------------------------------------------
module tmds_encoder_multi #(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_valid,
    input  logic [2:0]              i_mode,
    input  logic [NUM_CH*8-1:0]     i_data,
    input  logic [NUM_CH*2-1:0]     i_ctrl,
    input  logic [NUM_CH*4-1:0]     i_terc4,
    output logic                    o_valid,
    output logic [NUM_CH*10-1:0]    o_q,
    output logic [NUM_CH*CNT_W-1:0] o_disp
);
    localparam int STAGES = 2;

    // vld_pipe[1] = stage-1 valid, vld_pipe[STAGES] = output valid
    logic [STAGES:1] vld_pipe;

    // Valid flag shift register; bubbles travel alongside the data
    always_ff @(posedge clk) begin
        if (rst) vld_pipe <= '0;
        else     vld_pipe <= {vld_pipe[STAGES-1:1], i_valid};
    end

    assign o_valid = vld_pipe[STAGES];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        tmds_lane #(
            .LANE  (g),
            .CNT_W (CNT_W)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .load     (i_valid),
            .s1_valid (vld_pipe[1]),
            .mode     (i_mode),
            .data     (i_data[8*g +: 8]),
            .ctrl     (i_ctrl[2*g +: 2]),
            .terc4    (i_terc4[4*g +: 4]),
            .q        (o_q[10*g +: 10]),
            .disp     (o_disp[CNT_W*g +: CNT_W])
        );
    end
endmodule

// File: tb/tb_tmds_encoder_multi.sv
// Directed bench for tmds_encoder_multi (3 lanes, 6-bit disparity).
// Expected symbols and disparity values are worked out by hand.
module tb_tmds_encoder_multi;
    localparam int NUM_CH = 3;
    localparam int CNT_W  = 6;

    localparam logic [9:0] C00 = 10'b0010101011;
    localparam logic [9:0] C01 = 10'b1101010100;
    localparam logic [9:0] C11 = 10'b1101010101;
    localparam logic [9:0] GBA = 10'b1011001100;
    localparam logic [9:0] GBB = 10'b0100110011;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    i_valid;
    logic [2:0]              i_mode;
    logic [NUM_CH*8-1:0]     i_data;
    logic [NUM_CH*2-1:0]     i_ctrl;
    logic [NUM_CH*4-1:0]     i_terc4;
    logic                    o_valid;
    logic [NUM_CH*10-1:0]    o_q;
    logic [NUM_CH*CNT_W-1:0] o_disp;

    int checks = 0;
    int errors = 0;

    tmds_encoder_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_mode  (i_mode),
        .i_data  (i_data),
        .i_ctrl  (i_ctrl),
        .i_terc4 (i_terc4),
        .o_valid (o_valid),
        .o_q     (o_q),
        .o_disp  (o_disp)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] m,
                         input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                         input logic [1:0] c,
                         input logic [3:0] t0, input logic [3:0] t1, input logic [3:0] t2);
        i_valid = v;
        i_mode  = m;
        i_data  = {d2, d1, d0};
        i_ctrl  = {c, c, c};
        i_terc4 = {t2, t1, t0};
    endtask

    function automatic logic [31:0] ql(input int n);
        return {22'b0, o_q[10*n +: 10]};
    endfunction

    function automatic logic [31:0] dl(input int n);
        return {26'b0, o_disp[CNT_W*n +: CNT_W]};
    endfunction

    function automatic logic [31:0] d6(input int v);
        return {26'b0, v[5:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_q3(input string tag, input logic [9:0] e0, input logic [9:0] e1,
                          input logic [9:0] e2);
        chk({tag, "_q0"}, ql(0), {22'b0, e0});
        chk({tag, "_q1"}, ql(1), {22'b0, e1});
        chk({tag, "_q2"}, ql(2), {22'b0, e2});
    endtask

    task automatic chk_d3(input string tag, input int e0, input int e1, input int e2);
        chk({tag, "_d0"}, dl(0), d6(e0));
        chk({tag, "_d1"}, dl(1), d6(e1));
        chk({tag, "_d2"}, dl(2), d6(e2));
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 2'b00, 4'h0, 4'h0, 4'h0);
        cyc(); cyc(); cyc();
        chk("rst_valid", {31'b0, o_valid}, 32'd0);
        chk_q3("rst", C00, C00, C00);
        chk_d3("rst", 0, 0, 0);

        // X1: CTRL 11 right after release
        rst = 1'b0;
        drive(1'b1, 3'd0, 8'h00, 8'h00, 8'h00, 2'b11, 4'h0, 4'h0, 4'h0);
        cyc();
        chk("empty_after_rst", {31'b0, o_valid}, 32'd0);

        // X2: VIDEO lane bytes 00 / FF / 55
        drive(1'b1, 3'd1, 8'h00, 8'hFF, 8'h55, 2'b00, 4'h0, 4'h0, 4'h0);
        cyc();
        chk("ctrl11_valid", {31'b0, o_valid}, 32'd1);
        chk_q3("ctrl11", C11, C11, C11);

        // X3: same bytes again
        cyc();
        chk_q3("vid1", 10'b0100000000, 10'b1000000000, 10'b0100110011);
        chk_d3("vid1", -8, -8, 0);

        // X4: single CTRL 00 symbol
        drive(1'b1, 3'd0, 8'h00, 8'h00, 8'h00, 2'b00, 4'h0, 4'h0, 4'h0);
        cyc();
        chk_q3("vid2", 10'b1111111111, 10'b0011111111, 10'b0100110011);
        chk_d3("vid2", 2, -2, 0);

        // X5: VIDEO 00 after CTRL (start of the 1,0,1 pattern)
        drive(1'b1, 3'd1, 8'h00, 8'h00, 8'h00, 2'b00, 4'h0, 4'h0, 4'h0);
        cyc();
        chk_q3("ctrl00", C00, C00, C00);
        chk_d3("ctrl00", 0, 0, 0);

        // X6: bubble with junk data
        drive(1'b0, 3'd1, 8'hFF, 8'hFF, 8'hFF, 2'b00, 4'h0, 4'h0, 4'h0);
        cyc();
        chk("bub_v1", {31'b0, o_valid}, 32'd1);
        chk("after_ctrl_q0", ql(0), {22'b0, 10'b0100000000});
        chk("after_ctrl_d0", dl(0), d6(-8));

        // X7: VIDEO 00 after the bubble
        drive(1'b1, 3'd1, 8'h00, 8'h00, 8'h00, 2'b00, 4'h0, 4'h0, 4'h0);
        cyc();
        chk("bub_v0", {31'b0, o_valid}, 32'd0);
        chk("bub_hold_q0", ql(0), {22'b0, 10'b0100000000});
        chk("bub_hold_d0", dl(0), d6(-8));

        // X8: VIDEO guard band
        drive(1'b1, 3'd2, 8'h00, 8'h00, 8'h00, 2'b00, 4'h0, 4'h0, 4'h0);
        cyc();
        chk("bub_v2", {31'b0, o_valid}, 32'd1);
        chk("bub_q0", ql(0), {22'b0, 10'b1111111111});
        chk("bub_d0", dl(0), d6(2));

        // X9: ISLAND guard band, lane-0 nibble C
        drive(1'b1, 3'd4, 8'h00, 8'h00, 8'h00, 2'b01, 4'hC, 4'h5, 4'h5);
        cyc();
        chk_q3("vgb", GBA, GBB, GBA);
        chk_d3("vgb", 0, 0, 0);

        // X10: ISLAND nibbles 0 / 8 / F
        drive(1'b1, 3'd3, 8'h00, 8'h00, 8'h00, 2'b01, 4'h0, 4'h8, 4'hF);
        cyc();
`ifdef TMDS_DATA_ISLAND_EN
        chk_q3("igb", 10'b1010001110, GBB, GBB);
`else
        chk_q3("igb", C01, C01, C01);
`endif

        // X11, X12: VIDEO 00 to fill both stages
        drive(1'b1, 3'd1, 8'h00, 8'h00, 8'h00, 2'b00, 4'h0, 4'h0, 4'h0);
        cyc();
`ifdef TMDS_DATA_ISLAND_EN
        chk_q3("isl", 10'b1010011100, 10'b1011001100, 10'b1011000011);
`else
        chk_q3("isl", C01, C01, C01);
`endif
        chk_d3("isl", 0, 0, 0);
        cyc();
        chk_q3("pre_rst", 10'b0100000000, 10'b0100000000, 10'b0100000000);
        chk_d3("pre_rst", -8, -8, -8);

        // mid-stream reset with VIDEO in both stages
        rst = 1'b1;
        cyc();
        chk("mid_rst_valid", {31'b0, o_valid}, 32'd0);
        chk_q3("mid_rst", C00, C00, C00);
        chk_d3("mid_rst", 0, 0, 0);

        rst = 1'b0;
        cyc();
        chk("post_rst_empty", {31'b0, o_valid}, 32'd0);
        cyc();
        chk("post_rst_valid", {31'b0, o_valid}, 32'd1);
        chk_q3("post_rst", 10'b0100000000, 10'b0100000000, 10'b0100000000);
        chk_d3("post_rst", -8, -8, -8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
